multicycle_control: RTL and testbench

Parametrised multi-cycle control unit for the accumulator CPU: replaces the single-cycle opcode decoder with a FETCH/DECODE/MEM/WB state machine that handshakes with instruction and data memory. It resolves BCC/BNE from live flags, traps illegal opcodes and memory timeouts, and counts retired instructions. It sits between the instruction register/PC and the datapath muxes, ALU, T/A registers and data memory.

---
 rtl/ctrl_pkg.sv | 73 +++++++
 rtl/ctrl_decode.sv | 36 +++
 rtl/multicycle_control.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode map, FSM states,
// instruction classes, ALU operation codes and trap causes.
package ctrl_pkg;

    // Opcode map (4-bit architectural opcodes)
    localparam logic [3:0] OP_JMP = 4'b0000;
    localparam logic [3:0] OP_ADC = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SBR = 4'b0011;
    localparam logic [3:0] OP_ROR = 4'b0100;
    localparam logic [3:0] OP_TAT = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_ILL = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_LDC = 4'b1001;
    localparam logic [3:0] OP_BCC = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1011;
    localparam logic [3:0] OP_LDI = 4'b1100;
    localparam logic [3:0] OP_STT = 4'b1101;
    localparam logic [3:0] OP_LDA = 4'b1110;
    localparam logic [3:0] OP_STA = 4'b1111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADC = 3'b000;
    localparam logic [2:0] ALU_SBR = 3'b001;
    localparam logic [2:0] ALU_ROR = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    // Trap causes
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // PC source selects
    localparam logic [1:0] SRC_PC_INC = 2'b00;
    localparam logic [1:0] SRC_PC_VEC = 2'b01;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU_RD,
        CLS_LOAD,
        CLS_LOADI,
        CLS_STORE_T,
        CLS_STORE_A,
        CLS_REG,
        CLS_BRANCH,
        CLS_ILLEGAL
    } instr_class_t;

    // ALU operation for an ALU-class or ROR opcode; ADC for anything else
    function automatic logic [2:0] alu_code(input logic [3:0] op);
        logic [2:0] code;
        case (op)
            OP_SBR:  code = ALU_SBR;
            OP_XOR:  code = ALU_XOR;
            OP_OR:   code = ALU_OR;
            OP_AND:  code = ALU_AND;
            OP_ROR:  code = ALU_ROR;
            default: code = ALU_ADC;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational classifier: latched opcode -> instruction class.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode_q,
    output instr_class_t        instr_class
);

    logic [3:0] op_lo;
    logic       upper_zero;

    // Any set bit above the 4-bit opcode space makes the word illegal
    assign op_lo      = 4'(opcode_q);
    assign upper_zero = ((opcode_q >> 4) == '0);

    // Map the 4-bit opcode onto its execution class
    always_comb begin
        instr_class = CLS_ILLEGAL;
        if (upper_zero) begin
            case (op_lo)
                OP_ADC, OP_XOR, OP_SBR,
                OP_OR, OP_AND:          instr_class = CLS_ALU_RD;
                OP_LDC, OP_LDA:         instr_class = CLS_LOAD;
                OP_LDI:                 instr_class = CLS_LOADI;
                OP_STT:                 instr_class = CLS_STORE_T;
                OP_STA:                 instr_class = CLS_STORE_A;
                OP_ROR, OP_TAT:         instr_class = CLS_REG;
                OP_JMP, OP_BCC, OP_BNE: instr_class = CLS_BRANCH;
                default:                instr_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/MEM/WB control unit with memory handshakes,
// illegal-opcode and memory-timeout traps, and a retired-instruction counter.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned ALU_OP_W    = 3,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                imem_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                dmem_ready,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic                ir_load,
    output logic                pc_en,
    output logic [1:0]          src_pc,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                wr_t,
    output logic                wr_a,
    output logic                src_a,
    output logic                wr_dmem,
    output logic                rd_dmem,
    output logic                src_adr,
    output logic                src_data,
    output logic                busy,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    retired
);

    localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [CNT_W-1:0]    retired_q;
    logic [1:0]          cause_q, cause_d;
    logic [3:0]          op_lo;
    instr_class_t        cls;

    assign op_lo      = 4'(opcode_q);
    assign trap_cause = cause_q;
    assign retired    = retired_q;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode_q    (opcode_q),
        .instr_class (cls)
    );

    // State and trap-cause registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Instruction register: capture the opcode on ir_load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= '0;
        end else if (ir_load) begin
            opcode_q <= opcode;
        end
    end

    // MEM wait counter; held at zero outside MEM so every MEM entry starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (state_q == ST_MEM) begin
            wait_q <= wait_q + 1'b1;
        end else begin
            wait_q <= '0;
        end
    end

    // Retired-instruction counter, wraps naturally; pc_en never fires in TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (pc_en) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    // Next-state and control-output decode
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        ir_load  = 1'b0;
        pc_en    = 1'b0;
        src_pc   = SRC_PC_INC;
        alu_op   = '0;
        wr_t     = 1'b0;
        wr_a     = 1'b0;
        src_a    = 1'b0;
        wr_dmem  = 1'b0;
        rd_dmem  = 1'b0;
        src_adr  = 1'b0;
        src_data = 1'b0;
        busy     = 1'b0;
        trap     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                busy = 1'b1;
                case (cls)
                    CLS_ALU_RD, CLS_LOAD, CLS_LOADI,
                    CLS_STORE_T, CLS_STORE_A: state_d = ST_MEM;
                    CLS_REG, CLS_BRANCH:      state_d = ST_WB;
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end

            ST_MEM: begin
                busy = 1'b1;
                case (cls)
                    CLS_ALU_RD, CLS_LOAD: rd_dmem = 1'b1;
                    CLS_LOADI: begin
                        rd_dmem = 1'b1;
                        src_adr = 1'b1;
                    end
                    CLS_STORE_T: begin
                        wr_dmem  = 1'b1;
                        src_adr  = 1'b1;
                        src_data = 1'b1;
                    end
                    CLS_STORE_A: wr_dmem = 1'b1;
                    default: ;
                endcase
                // Completion wins over timeout when both land on the same cycle
                if (dmem_ready) begin
                    if (cls == CLS_STORE_T || cls == CLS_STORE_A) begin
                        pc_en   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end

            ST_WB: begin
                busy    = 1'b1;
                pc_en   = 1'b1;
                state_d = ST_FETCH;
                case (cls)
                    CLS_ALU_RD: begin
                        wr_a   = 1'b1;
                        alu_op = ALU_OP_W'(alu_code(op_lo));
                    end
                    CLS_LOAD, CLS_LOADI: begin
                        wr_a  = 1'b1;
                        src_a = 1'b1;
                    end
                    CLS_REG: begin
                        if (op_lo == OP_ROR) begin
                            wr_a   = 1'b1;
                            alu_op = ALU_OP_W'(ALU_ROR);
                        end else begin
                            wr_t = 1'b1;
                        end
                    end
                    CLS_BRANCH: begin
                        case (op_lo)
                            OP_JMP:  src_pc = SRC_PC_VEC;
                            OP_BCC:  src_pc = flag_c ? SRC_PC_INC : SRC_PC_VEC;
                            OP_BNE:  src_pc = flag_z ? SRC_PC_INC : SRC_PC_VEC;
                            default: src_pc = SRC_PC_INC;
                        endcase
                    end
                    default: ;
                endcase
            end

            ST_TRAP: begin
                trap = 1'b1;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a
// randomized instruction stream checked against a transaction-level model.
module tb_multicycle_control;

    // Opcodes as the bench understands the instruction set
    localparam logic [3:0] T_JMP = 4'h0, T_ADC = 4'h1, T_XOR = 4'h2, T_SBR = 4'h3;
    localparam logic [3:0] T_ROR = 4'h4, T_TAT = 4'h5, T_OR  = 4'h6, T_ILL = 4'h7;
    localparam logic [3:0] T_AND = 4'h8, T_LDC = 4'h9, T_BCC = 4'hA, T_BNE = 4'hB;
    localparam logic [3:0] T_LDI = 4'hC, T_STT = 4'hD, T_LDA = 4'hE, T_STA = 4'hF;

    // Packed observation: {ir_load, pc_en, src_pc, alu_op, wr_t, wr_a, src_a,
    //                      wr_dmem, rd_dmem, src_adr, src_data, busy, trap, trap_cause}
    localparam logic [17:0] IR   = 18'h20000, PC   = 18'h10000, VEC  = 18'h04000;
    localparam logic [17:0] WT   = 18'h00400, WA   = 18'h00200, SA   = 18'h00100;
    localparam logic [17:0] WD   = 18'h00080, RD   = 18'h00040, SADR = 18'h00020;
    localparam logic [17:0] SDAT = 18'h00010, BUSY = 18'h00008, TRAP = 18'h00004;
    localparam logic [17:0] TC_ILL = 18'h00001, TC_TO = 18'h00002;
    localparam int MEM_T_A = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       imem_ready = 1'b0;
    logic [3:0] opcode = '0;
    logic       dmem_ready = 1'b0;
    logic       flag_c = 1'b0;
    logic       flag_z = 1'b0;

    logic        ir_load_a, pc_en_a, wr_t_a, wr_a_a, src_a_a, wr_dmem_a, rd_dmem_a;
    logic        src_adr_a, src_data_a, busy_a, trap_a;
    logic [1:0]  src_pc_a, trap_cause_a;
    logic [2:0]  alu_op_a;
    logic [15:0] retired_a;
    logic        ir_load_b, pc_en_b, wr_t_b, wr_a_b, src_a_b, wr_dmem_b, rd_dmem_b;
    logic        src_adr_b, src_data_b, busy_b, trap_b;
    logic [1:0]  src_pc_b, trap_cause_b;
    logic [2:0]  alu_op_b;
    logic [3:0]  retired_b;
    logic [17:0] obs_a, obs_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control dut_a (
        .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .opcode(opcode),
        .dmem_ready(dmem_ready), .flag_c(flag_c), .flag_z(flag_z),
        .ir_load(ir_load_a), .pc_en(pc_en_a), .src_pc(src_pc_a), .alu_op(alu_op_a),
        .wr_t(wr_t_a), .wr_a(wr_a_a), .src_a(src_a_a), .wr_dmem(wr_dmem_a),
        .rd_dmem(rd_dmem_a), .src_adr(src_adr_a), .src_data(src_data_a),
        .busy(busy_a), .trap(trap_a), .trap_cause(trap_cause_a), .retired(retired_a)
    );

    multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .opcode(opcode),
        .dmem_ready(dmem_ready), .flag_c(flag_c), .flag_z(flag_z),
        .ir_load(ir_load_b), .pc_en(pc_en_b), .src_pc(src_pc_b), .alu_op(alu_op_b),
        .wr_t(wr_t_b), .wr_a(wr_a_b), .src_a(src_a_b), .wr_dmem(wr_dmem_b),
        .rd_dmem(rd_dmem_b), .src_adr(src_adr_b), .src_data(src_data_b),
        .busy(busy_b), .trap(trap_b), .trap_cause(trap_cause_b), .retired(retired_b)
    );

    assign obs_a = {ir_load_a, pc_en_a, src_pc_a, alu_op_a, wr_t_a, wr_a_a, src_a_a,
                    wr_dmem_a, rd_dmem_a, src_adr_a, src_data_a, busy_a, trap_a, trap_cause_a};
    assign obs_b = {ir_load_b, pc_en_b, src_pc_b, alu_op_b, wr_t_b, wr_a_b, src_a_b,
                    wr_dmem_b, rd_dmem_b, src_adr_b, src_data_b, busy_b, trap_b, trap_cause_b};

    function automatic logic [17:0] alu_f(input logic [2:0] x);
        return {4'b0, x, 11'b0};
    endfunction

    function automatic bit is_store(input logic [3:0] op);
        return (op == T_STT) || (op == T_STA);
    endfunction

    function automatic bit is_mem(input logic [3:0] op);
        return is_store(op) || op == T_ADC || op == T_XOR || op == T_SBR || op == T_OR ||
               op == T_AND || op == T_LDC || op == T_LDA || op == T_LDI;
    endfunction

    // Strobes held while a data-memory access is outstanding
    function automatic logic [17:0] mem_exp(input logic [3:0] op);
        case (op)
            T_LDI:   return BUSY | RD | SADR;
            T_STT:   return BUSY | WD | SADR | SDAT;
            T_STA:   return BUSY | WD;
            default: return BUSY | RD;
        endcase
    endfunction

    // Write-back cycle outputs for a given instruction and live flags
    function automatic logic [17:0] wb_exp(input logic [3:0] op, input logic fc, input logic fz);
        logic [17:0] e;
        e = BUSY | PC;
        case (op)
            T_ADC: e |= WA | alu_f(3'b000);
            T_SBR: e |= WA | alu_f(3'b001);
            T_XOR: e |= WA | alu_f(3'b101);
            T_OR:  e |= WA | alu_f(3'b110);
            T_AND: e |= WA | alu_f(3'b111);
            T_ROR: e |= WA | alu_f(3'b100);
            T_LDC, T_LDA, T_LDI: e |= WA | SA;
            T_TAT: e |= WT;
            T_JMP: e |= VEC;
            T_BCC: if (!fc) e |= VEC;
            T_BNE: if (!fz) e |= VEC;
            default: ;
        endcase
        return e;
    endfunction

    // Apply inputs just after the falling edge and let outputs settle
    task automatic drive(input logic im, input logic [3:0] op, input logic dm,
                         input logic fc, input logic fz);
        @(negedge clk);
        imem_ready = im;
        opcode     = op;
        dmem_ready = dm;
        flag_c     = fc;
        flag_z     = fz;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_ready = 1'b0; opcode = '0; dmem_ready = 1'b0; flag_c = 1'b0; flag_z = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({retired_a, obs_a} !== '0) begin
            n_fail++; $display("FAIL reset_a: got ret=%0d obs=%h expected 0/0", retired_a, obs_a);
        end
        n_checks++;
        if ({retired_b, obs_b} !== '0) begin
            n_fail++; $display("FAIL reset_b: got ret=%0d obs=%h expected 0/0", retired_b, obs_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({retired_a, obs_a} !== '0) begin
            n_fail++; $display("FAIL reset_release: got ret=%0d obs=%h expected 0/0", retired_a, obs_a);
        end
    endtask

    task automatic test_adc_ready_high();
        logic [17:0] exp_seq [4];
        exp_seq = '{IR, BUSY, BUSY | RD, BUSY | PC | WA | alu_f(3'b000)};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, (i == 0) ? T_ADC : 4'h0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs_a !== exp_seq[i]) begin
                n_fail++; $display("FAIL adc_cycle%0d: got %h expected %h", i, obs_a, exp_seq[i]);
            end
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({retired_a, obs_a} !== {16'd1, 18'h0}) begin
            n_fail++; $display("FAIL adc_retired: got ret=%0d obs=%h expected 1/0", retired_a, obs_a);
        end
    endtask

    task automatic test_stt_wait();
        logic [15:0] ret0;
        ret0 = retired_a;
        drive(1'b1, T_STT, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, T_ADC, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_a !== (BUSY | WD | SADR | SDAT)) begin
                n_fail++; $display("FAIL stt_wait%0d: got %h expected %h", i, obs_a, BUSY | WD | SADR | SDAT);
            end
        end
        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs_a !== (BUSY | WD | SADR | SDAT | PC)) begin
            n_fail++; $display("FAIL stt_done: got %h expected %h", obs_a, BUSY | WD | SADR | SDAT | PC);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({retired_a, obs_a} !== {ret0 + 16'd1, 18'h0}) begin
            n_fail++; $display("FAIL stt_no_wb: got ret=%0d obs=%h expected %0d/0", retired_a, obs_a, ret0 + 16'd1);
        end
    endtask

    task automatic test_branches();
        logic [3:0]  ops [4];
        logic        fcs [4];
        logic        fzs [4];
        logic [17:0] exps [4];
        ops  = '{T_BNE, T_BNE, T_BCC, T_BCC};
        fcs  = '{1'b1, 1'b0, 1'b1, 1'b0};
        fzs  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exps = '{BUSY | PC | VEC, BUSY | PC, BUSY | PC, BUSY | PC | VEC};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], 1'b0, 1'b0, 1'b0);
            drive(1'b0, 4'h0, 1'b0, ~fcs[i], ~fzs[i]);
            drive(1'b0, 4'h0, 1'b0, fcs[i], fzs[i]);
            n_checks++;
            if (obs_a !== exps[i]) begin
                n_fail++; $display("FAIL branch%0d: got %h expected %h", i, obs_a, exps[i]);
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1'b1, T_ILL, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, T_ADC, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs_a !== (TRAP | TC_ILL)) begin
            n_fail++; $display("FAIL illegal_trap: got %h expected %h", obs_a, TRAP | TC_ILL);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, T_ADC, 1'b1, 1'($urandom), 1'($urandom));
            n_checks++;
            if ({retired_a, obs_a} !== {16'd0, TRAP | TC_ILL}) begin
                n_fail++; $display("FAIL illegal_sticky%0d: got ret=%0d obs=%h expected 0/%h", i, retired_a, obs_a, TRAP | TC_ILL);
            end
        end
        do_reset();
        drive(1'b1, T_ADC, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_a !== IR) begin
            n_fail++; $display("FAIL illegal_cleared: got %h expected %h", obs_a, IR);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(1'b1, T_LDA, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'h0, i == 3, 1'b0, 1'b0);
            n_checks++;
            if (obs_b !== (BUSY | RD)) begin
                n_fail++; $display("FAIL timeout_edge%0d: got %h expected %h", i, obs_b, BUSY | RD);
            end
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_b !== (BUSY | PC | WA | SA)) begin
            n_fail++; $display("FAIL timeout_edge_wb: got %h expected %h", obs_b, BUSY | PC | WA | SA);
        end
        drive(1'b1, T_LDA, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_b !== (BUSY | RD)) begin
                n_fail++; $display("FAIL timeout_wait%0d: got %h expected %h", i, obs_b, BUSY | RD);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, T_ADC, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if ({retired_b, obs_b} !== {4'd1, TRAP | TC_TO}) begin
                n_fail++; $display("FAIL timeout_trap%0d: got ret=%0d obs=%h expected 1/%h", i, retired_b, obs_b, TRAP | TC_TO);
            end
        end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, T_TAT, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_b !== (BUSY | PC | WT)) begin
                n_fail++; $display("FAIL tat_wb%0d: got %h expected %h", i, obs_b, BUSY | PC | WT);
            end
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (retired_b !== 4'd1) begin
            n_fail++; $display("FAIL retired_wrap: got %0d expected 1", retired_b);
        end
        drive(1'b1, T_LDA, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_b !== (BUSY | RD)) begin
            n_fail++; $display("FAIL pre_reset_mem: got %h expected %h", obs_b, BUSY | RD);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({retired_b, obs_b} !== '0) begin
            n_fail++; $display("FAIL async_reset: got ret=%0d obs=%h expected 0/0", retired_b, obs_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, T_ADC, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_b !== IR) begin
            n_fail++; $display("FAIL fetch_after_reset: got %h expected %h", obs_b, IR);
        end
    endtask

    // Random instruction stream on dut_a, expected cycles built per instruction
    task automatic test_random_stream();
        logic [15:0] exp_ret;
        logic [17:0] e;
        logic [3:0]  op;
        logic        fc, fz, ready, done;
        int          idle, k;
        do_reset();
        exp_ret = '0;
        for (int n = 0; n < 60; n++) begin
            op   = 4'($urandom_range(0, 15));
            idle = $urandom_range(0, 2);
            for (int i = 0; i < idle; i++) begin
                drive(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                n_checks++;
                if ({retired_a, obs_a} !== {exp_ret, 18'h0}) begin
                    n_fail++; $display("FAIL rnd_idle n=%0d: got ret=%0d obs=%h expected %0d/0", n, retired_a, obs_a, exp_ret);
                end
            end
            drive(1'b1, op, 1'($urandom), 1'($urandom), 1'($urandom));
            n_checks++;
            if ({retired_a, obs_a} !== {exp_ret, IR}) begin
                n_fail++; $display("FAIL rnd_fetch n=%0d op=%h: got ret=%0d obs=%h expected %0d/%h", n, op, retired_a, obs_a, exp_ret, IR);
            end
            drive(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            n_checks++;
            if ({retired_a, obs_a} !== {exp_ret, BUSY}) begin
                n_fail++; $display("FAIL rnd_decode n=%0d op=%h: got ret=%0d obs=%h expected %0d/%h", n, op, retired_a, obs_a, exp_ret, BUSY);
            end
            if (op == T_ILL) begin
                drive(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                n_checks++;
                if ({retired_a, obs_a} !== {exp_ret, TRAP | TC_ILL}) begin
                    n_fail++; $display("FAIL rnd_illegal n=%0d: got ret=%0d obs=%h expected %0d/%h", n, retired_a, obs_a, exp_ret, TRAP | TC_ILL);
                end
                do_reset();
                exp_ret = '0;
                continue;
            end
            if (is_mem(op)) begin
                k = ($urandom_range(0, 3) == 0) ? $urandom_range(MEM_T_A - 2, MEM_T_A + 1)
                                                : $urandom_range(0, 3);
                done = 1'b0;
                for (int i = 0; i < MEM_T_A && !done; i++) begin
                    ready = (i == k);
                    drive(1'($urandom), 4'($urandom), ready, 1'($urandom), 1'($urandom));
                    e = mem_exp(op) | ((ready && is_store(op)) ? PC : 18'h0);
                    n_checks++;
                    if ({retired_a, obs_a} !== {exp_ret, e}) begin
                        n_fail++; $display("FAIL rnd_mem n=%0d op=%h wait=%0d: got ret=%0d obs=%h expected %0d/%h", n, op, i, retired_a, obs_a, exp_ret, e);
                    end
                    done = ready;
                end
                if (!done) begin
                    drive(1'b1, 4'($urandom), 1'b1, 1'($urandom), 1'($urandom));
                    n_checks++;
                    if ({retired_a, obs_a} !== {exp_ret, TRAP | TC_TO}) begin
                        n_fail++; $display("FAIL rnd_timeout n=%0d: got ret=%0d obs=%h expected %0d/%h", n, retired_a, obs_a, exp_ret, TRAP | TC_TO);
                    end
                    do_reset();
                    exp_ret = '0;
                    continue;
                end
                if (is_store(op)) begin
                    exp_ret++;
                    continue;
                end
            end
            fc = 1'($urandom);
            fz = 1'($urandom);
            drive(1'($urandom), 4'($urandom), 1'($urandom), fc, fz);
            e = wb_exp(op, fc, fz);
            n_checks++;
            if ({retired_a, obs_a} !== {exp_ret, e}) begin
                n_fail++; $display("FAIL rnd_wb n=%0d op=%h c=%b z=%b: got ret=%0d obs=%h expected %0d/%h", n, op, fc, fz, retired_a, obs_a, exp_ret, e);
            end
            exp_ret++;
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_adc_ready_high();
        test_stt_wait();
        test_branches();
        test_illegal();
        test_timeout();
        test_wrap_and_async_reset();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the test sequence completed");
        $fatal(1);
    end

endmodule
